// File: rtl/pulse_param_loader.sv
// -----------------------------------------------------------------------------
// pulse_param_loader
//
// Collects framed bytes from the UART receiver and turns them into the pulse
// generator's complete parameter set. A frame is SYNC_BYTE, 20 payload bytes
// and an 8-bit mod-256 checksum of the payload. The live outputs change only
// when a frame with a good checksum is committed. The cycle after a commit,
// a one-cycle strobe on rxd tells the generator to load the new values.
//
// Ports
//   clk_pll    in   1   system clock (200 MHz), the only clock
//   reset      in   1   asynchronous, active-low reset
//   rx_data    in   8   received byte
//   rx_valid   in   1   rx_data is valid in this cycle (one byte per cycle)
//   pu, bl     out  1   pump enable, blocking enable
//   per        out  8   period
//   p1wid      out  16  first pulse width
//   del        out  16  inter-pulse delay
//   p2wid      out  16  second pulse width
//   nut_w      out  32  nutation pulse width
//   nut_d      out  32  nutation delay
//   cp         out  8   mode / number of pi pulses
//   p_bl       out  8   block lead time
//   p_bl_off   out  16  block-open window
//   rxd        out  1   load strobe, one cycle per committed frame
//   frame_ok   out  1   one-cycle pulse when a frame is committed
//   frame_err  out  1   one-cycle pulse on checksum error, timeout or a byte
//                       arriving during the commit cycle
//   err_count  out  8   saturating count of frame errors
// -----------------------------------------------------------------------------
module pulse_param_loader #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT   = 2_000_000
) (
   input  logic        clk_pll,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        pu,
   output logic        bl,
   output logic [7:0]  per,
   output logic [15:0] p1wid,
   output logic [15:0] del,
   output logic [15:0] p2wid,
   output logic [31:0] nut_w,
   output logic [31:0] nut_d,
   output logic [7:0]  cp,
   output logic [7:0]  p_bl,
   output logic [15:0] p_bl_off,
   output logic        rxd,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [7:0]  err_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PAYLOAD = 3'd1,
      S_CHECK   = 3'd2,
      S_COMMIT  = 3'd3,
      S_STROBE  = 3'd4
   } state_t;

   localparam logic [23:0] TMO_LIM  = 24'(TIMEOUT);
   localparam logic [4:0]  LAST_IDX = 5'd19;

   // Power-on / reset parameter set.
   localparam logic        DEF_PU       = 1'b1;
   localparam logic        DEF_BL       = 1'b1;
   localparam logic [7:0]  DEF_PER      = 8'd1;
   localparam logic [15:0] DEF_P1WID    = 16'd30;
   localparam logic [15:0] DEF_DEL      = 16'd200;
   localparam logic [15:0] DEF_P2WID    = 16'd30;
   localparam logic [31:0] DEF_NUT_W    = 32'd50;
   localparam logic [31:0] DEF_NUT_D    = 32'd300;
   localparam logic [7:0]  DEF_CP       = 8'd3;
   localparam logic [7:0]  DEF_P_BL     = 8'd50;
   localparam logic [15:0] DEF_P_BL_OFF = 16'd100;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  idx;
   logic [7:0]  sum;
   logic [23:0] tmo_cnt;

   // Shadow copy of the payload. Only bits 1:0 of the flags byte are
   // meaningful, so the flags byte is captured separately and the remaining
   // 19 bytes shift in big-endian order into shadow_body.
   logic [1:0]   shadow_flags;
   logic [151:0] shadow_body;

   logic is_sync;
   logic in_frame;
   logic tmo_hit;
   logic start_frame;
   logic take_byte;
   logic err_evt;
   logic do_commit;

   assign is_sync  = (rx_data == SYNC_BYTE);
   assign in_frame = (state == S_PAYLOAD) || (state == S_CHECK);
   // The timeout wins over a byte arriving in the same cycle.
   assign tmo_hit  = in_frame && (tmo_cnt == TMO_LIM);

   // State register
   always_ff @(posedge clk_pll or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (rx_valid && is_sync) begin
               state_nxt = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (tmo_hit) begin
               state_nxt = S_IDLE;
            end else if (rx_valid && (idx == LAST_IDX)) begin
               state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (tmo_hit) begin
               state_nxt = S_IDLE;
            end else if (rx_valid) begin
               state_nxt = (rx_data == sum) ? S_COMMIT : S_IDLE;
            end
         end
         S_COMMIT: begin
            state_nxt = S_STROBE;
         end
         S_STROBE: begin
            // A byte in the strobe cycle is handled exactly as in IDLE, so a
            // sync byte here starts the next frame without losing a cycle.
            state_nxt = (rx_valid && is_sync) ? S_PAYLOAD : S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output / control decode
   always_comb begin
      start_frame = 1'b0;
      take_byte   = 1'b0;
      err_evt     = 1'b0;
      do_commit   = 1'b0;
      case (state)
         S_IDLE: begin
            start_frame = rx_valid && is_sync;
         end
         S_PAYLOAD: begin
            take_byte = rx_valid && !tmo_hit;
            err_evt   = tmo_hit;
         end
         S_CHECK: begin
            err_evt = tmo_hit || (rx_valid && (rx_data != sum));
         end
         S_COMMIT: begin
            do_commit = 1'b1;
            // Nothing can accept a byte during the commit cycle.
            err_evt   = rx_valid;
         end
         S_STROBE: begin
            start_frame = rx_valid && is_sync;
         end
         default: begin
            start_frame = 1'b0;
         end
      endcase
   end

   // Frame bookkeeping: byte index, running checksum, idle timer
   always_ff @(posedge clk_pll or negedge reset) begin
      if (!reset) begin
         idx     <= 5'd0;
         sum     <= 8'd0;
         tmo_cnt <= 24'd0;
      end else begin
         if (start_frame) begin
            idx <= 5'd0;
            sum <= 8'd0;
         end else if (take_byte) begin
            idx <= idx + 5'd1;
            sum <= sum + rx_data;
         end

         if (!in_frame || rx_valid) begin
            tmo_cnt <= 24'd0;
         end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
         end
      end
   end

   // Payload shadow (data only; partial contents after an abort are harmless
   // because they are never committed)
   always_ff @(posedge clk_pll) begin
      if (take_byte) begin
         if (idx == 5'd0) begin
            shadow_flags <= rx_data[1:0];
         end else begin
            shadow_body <= {shadow_body[143:0], rx_data};
         end
      end
   end

   // Live parameters and status
   always_ff @(posedge clk_pll or negedge reset) begin
      if (!reset) begin
         pu        <= DEF_PU;
         bl        <= DEF_BL;
         per       <= DEF_PER;
         p1wid     <= DEF_P1WID;
         del       <= DEF_DEL;
         p2wid     <= DEF_P2WID;
         nut_w     <= DEF_NUT_W;
         nut_d     <= DEF_NUT_D;
         cp        <= DEF_CP;
         p_bl      <= DEF_P_BL;
         p_bl_off  <= DEF_P_BL_OFF;
         rxd       <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_count <= 8'd0;
      end else begin
         if (do_commit) begin
            pu       <= shadow_flags[0];
            bl       <= shadow_flags[1];
            per      <= shadow_body[151:144];
            p1wid    <= shadow_body[143:128];
            del      <= shadow_body[127:112];
            p2wid    <= shadow_body[111:96];
            nut_w    <= shadow_body[95:64];
            nut_d    <= shadow_body[63:32];
            cp       <= shadow_body[31:24];
            p_bl     <= shadow_body[23:16];
            p_bl_off <= shadow_body[15:0];
         end
         // rxd follows the commit by one cycle so the parameters are already
         // stable when the generator samples them.
         rxd       <= (state == S_STROBE);
         frame_ok  <= do_commit;
         frame_err <= err_evt;
         if (err_evt) begin
            err_count <= sat_inc8(err_count);
         end
      end
   end

endmodule

// File: doc/pulse_param_loader.md
# pulse_param_loader

Assembles a framed byte stream from the UART receiver into the full pulse-programme parameter set and hands it to the pulse generator. Frames are checked before use; only a frame with a good checksum replaces the live parameters. Each accepted frame produces a one-cycle transfer strobe on `rxd`, the generator's load input. Sits between the UART byte receiver and the pulse generator, in the `clk_pll` (200 MHz) domain.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT`, 2_000_000, maximum idle cycles between bytes inside a frame (10 ms at 200 MHz). Counter width is 24 bits.
- `clk_pll`  in  1  200 MHz system clock; the block's one clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `pu`, `bl`  out  1 each  pump enable and blocking enable.
- `per`  out  8  period field.
- `p1wid`, `del`, `p2wid`  out  16 each  first-pulse width, delay and second-pulse width.
- `nut_w`, `nut_d`  out  32 each  nutation pulse width and delay.
- `cp`  out  8  mode / number of pi pulses.
- `p_bl`  out  8  block lead time.
- `p_bl_off`  out  16  block-open window.
- `rxd`  out  1  transfer strobe; high for exactly one cycle per committed frame.
- `frame_ok`, `frame_err`  out  1 each  one-cycle status pulses.
- `err_count`  out  8  count of frame errors; saturates at 255.

## Operation
- Frame format: `SYNC_BYTE`, then 20 payload bytes, then 1 checksum byte. All multi-byte fields are big-endian.
- Payload byte order:
  - flags: bit0 = `pu`, bit1 = `bl`, bits 7:2 ignored
  - `per` (1 byte)
  - `p1wid` (2), `del` (2), `p2wid` (2)
  - `nut_w` (4), `nut_d` (4)
  - `cp` (1), `p_bl` (1), `p_bl_off` (2)
- Checksum: the 8-bit sum (mod 256) of the 20 payload bytes. The sync byte is excluded.
- Incoming payload bytes go into a 160-bit shadow register. The outputs change only in COMMIT.
- States:
  - IDLE: a byte equal to `SYNC_BYTE` moves to PAYLOAD and clears the byte index and running sum. Any other byte is discarded silently.
  - PAYLOAD: each byte goes to the shadow register at the current index, is added to the sum, and the index increments. After index 19 is written, move to CHECK. A byte equal to `SYNC_BYTE` here is ordinary data.
  - CHECK: the next byte is compared with the sum. On a match, move to COMMIT. On a mismatch, pulse `frame_err`, increment `err_count`, and return to IDLE.
  - COMMIT: copy the shadow register to all outputs, pulse `frame_ok`, move to STROBE.
  - STROBE: `rxd` = 1 for this cycle, then move to IDLE.
- Timeout: in PAYLOAD and CHECK, a counter clears on every `rx_valid` and increments otherwise. When it reaches `TIMEOUT`: pulse `frame_err`, increment `err_count`, return to IDLE. The shadow register keeps partial data, but that data is never committed.
- A byte arriving in COMMIT is dropped, with `frame_err` and an `err_count` increment.
- A byte arriving in STROBE is evaluated exactly as in IDLE, in the same cycle.
- Reset (asynchronous, at any time, including mid-frame):
  - state goes to IDLE; index, sum, timeout counter and `err_count` clear to 0
  - `rxd`, `frame_ok`, `frame_err` go to 0
  - outputs take their defaults: `pu`=1, `bl`=1, `per`=1, `p1wid`=30, `del`=200, `p2wid`=30, `nut_w`=50, `nut_d`=300, `cp`=3, `p_bl`=50, `p_bl_off`=100

## Timing
- Checksum byte sampled at edge T: state becomes COMMIT.
- Edge T+1: outputs update and `frame_ok` = 1.
- Edge T+2: `rxd` = 1.
- Edge T+3: `rxd` = 0.
- The outputs are therefore stable for at least one full cycle before `rxd` rises, and stay stable until the next commit.
- All outputs are registered. There are no combinational paths from input to output.
- Minimum legal frame: 22 `rx_valid` cycles. Back-to-back `rx_valid` on consecutive cycles must be handled.
- `rx_valid` held high on consecutive cycles counts as a new byte on each cycle.

## Test plan
- Good frame: A5 01 02 00 28 01 90 00 50 00 00 00 64 00 00 03 E8 01 32 00 C8, checksum 56.
  - Required: `pu`=1, `bl`=0, `per`=2, `p1wid`=40, `del`=400, `p2wid`=80, `nut_w`=100, `nut_d`=1000, `cp`=1, `p_bl`=50, `p_bl_off`=200.
  - Required: `frame_ok` one cycle after the checksum byte, and `rxd` one cycle after that, each exactly 1 cycle long.
- Same frame with checksum 57: outputs stay at their reset defaults, `rxd` never asserts, `frame_err` pulses once, `err_count`=1.
- Garbage bytes 00 FF 12 before the good frame: all ignored with no error, and the frame commits normally.
- Stall of `TIMEOUT` cycles after payload byte 10: `frame_err` pulses and the state returns to IDLE. Sending the full good frame afterwards then commits.
- Reset asserted after payload byte 15 of the first good frame: outputs return to defaults with no `rxd`. A complete frame sent after reset releases commits.
- 300 bad-checksum frames: `err_count` saturates at 255. Good frames sent back-to-back with `rx_valid` held continuously each commit with one `rxd` strobe.
